npc_gen: RTL and testbench

NPC_GEN -- requirements
Module: npc_gen

---
 rtl/npc_pkg.sv | 26 ++
 rtl/npc_pending.sv | 47 ++++
 rtl/npc_gen.sv | 129 ++++++++++++
 tb/tb_npc_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC generator: PC width, default step,
// FSM state encodings and small address helpers.
package npc_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP_DEF = 32'd4;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_RUN      = 3'd1,
    S_STALL    = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALT     = 3'd4
  } npc_state_e;

  // Redirect targets are word aligned by dropping the two low bits.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] t);
    return {t[PC_W-1:2], 2'b00};
  endfunction

  // A raw redirect target is misaligned when its two low bits are nonzero.
  function automatic logic is_misaligned(input logic [PC_W-1:0] t);
    return (t[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/npc_pending.sv
// One-entry hold register for a redirect target that arrives while the
// PC is stalled. Clear has priority over set; set overwrites any entry.
module npc_pending
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [PC_W-1:0] target_i,
  output logic            pend_v_o,
  output logic [PC_W-1:0] target_o
);

  logic            pend_v_d, pend_v_q;
  logic [PC_W-1:0] target_d, target_q;

  // Next-entry logic: clear, overwrite, or hold.
  always_comb begin
    pend_v_d = pend_v_q;
    target_d = target_q;
    if (clr_i) begin
      pend_v_d = 1'b0;
    end else if (set_i) begin
      pend_v_d = 1'b1;
      target_d = target_i;
    end else begin
      pend_v_d = pend_v_q;
      target_d = target_q;
    end
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      target_q <= {PC_W{1'b0}};
    end else begin
      pend_v_q <= pend_v_d;
      target_q <= target_d;
    end
  end

  assign pend_v_o = pend_v_q;
  assign target_o = target_q;

endmodule

// File: rtl/npc_gen.sv
// Next-PC generator: sequential increment, jump/branch redirect with a
// one-cycle bubble, stall with a one-entry pending redirect, sticky halt.
module npc_gen
  import npc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            clknpc,
  input  logic            rstnpc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] out_four,
  output logic            valid,
  output logic            misalign,
  output logic [2:0]      state_o
);

  npc_state_e      state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic            valid_d, valid_q;
  logic            misalign_d, misalign_q;

  logic            redirect_req;
  logic [PC_W-1:0] redirect_tgt;
  logic            pend_set;
  logic            pend_clr;
  logic            pend_v;
  logic [PC_W-1:0] pend_tgt;

  // Jump outranks branch when both are requested in the same cycle.
  assign redirect_req = jump | branch_taken;
  assign redirect_tgt = jump ? jump_target : branch_target;

  npc_pending u_pending (
    .clk      (clknpc),
    .rst      (rstnpc),
    .set_i    (pend_set),
    .clr_i    (pend_clr),
    .target_i (redirect_tgt),
    .pend_v_o (pend_v),
    .target_o (pend_tgt)
  );

  // Next-state, next-PC and pending control, priority halt > redirect > stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_RUN;
      end
      S_RUN, S_REDIRECT: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (redirect_req) begin
          pc_d       = align_pc(redirect_tgt);
          misalign_d = is_misaligned(redirect_tgt);
          state_d    = S_REDIRECT;
        end else if (stall) begin
          state_d = S_STALL;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_RUN;
        end
      end
      S_STALL: begin
        if (halt) begin
          state_d  = S_HALT;
          pend_clr = 1'b1;
        end else if (stall) begin
          pend_set = redirect_req;
        end else if (redirect_req) begin
          // A fresh redirect on release supersedes anything pending.
          pc_d       = align_pc(redirect_tgt);
          misalign_d = is_misaligned(redirect_tgt);
          state_d    = S_REDIRECT;
          pend_clr   = 1'b1;
        end else if (pend_v) begin
          pc_d       = align_pc(pend_tgt);
          misalign_d = is_misaligned(pend_tgt);
          state_d    = S_REDIRECT;
          pend_clr   = 1'b1;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RESET;
        pc_d    = RESET_PC;
      end
    endcase
    valid_d = ((state_d == S_RUN) || (state_d == S_STALL)) ? 1'b1 : 1'b0;
  end

  // State, PC and registered status outputs with synchronous reset.
  always_ff @(posedge clknpc) begin
    if (rstnpc) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out   = pc_q;
  assign out_four = pc_q + PC_STEP;
  assign valid    = valid_q;
  assign misalign = misalign_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_npc_gen.sv
// Scoreboard bench for npc_gen: two instances (default reset PC and a
// reset PC near the top of the address space) share one stimulus stream.
module tb_npc_gen;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp, halt;
  logic [31:0] bt, jt;

  logic [31:0] pc0, four0, pc1, four1;
  logic        v0, mis0, v1, mis1;
  logic [2:0]  st0, st1;

  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  npc_gen u_dut0 (
    .clknpc(clk), .rstnpc(rst), .stall(stall), .branch_taken(br),
    .branch_target(bt), .jump(jmp), .jump_target(jt), .halt(halt),
    .pc_out(pc0), .out_four(four0), .valid(v0), .misalign(mis0), .state_o(st0)
  );

  npc_gen #(.RESET_PC(RPC1)) u_dut1 (
    .clknpc(clk), .rstnpc(rst), .stall(stall), .branch_taken(br),
    .branch_target(bt), .jump(jmp), .jump_target(jt), .halt(halt),
    .pc_out(pc1), .out_four(four1), .valid(v1), .misalign(mis1), .state_o(st1)
  );

  always #5 clk = ~clk;

  typedef struct {
    npc_state_e  mode;
    logic [31:0] pc;
    logic        mis;
    logic        pv;
    logic [31:0] pt;
  } mdl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] four;
    logic        v;
    logic        mis;
    logic [2:0]  st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  mdl_t m0, m1;
  exp_t e0, e1;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic mdl_t redirect_to(input mdl_t s, input logic [31:0] t);
    mdl_t n;
    n      = s;
    n.pc   = t - (t % 32'd4);
    n.mis  = ((t % 32'd4) != 32'd0);
    n.mode = S_REDIRECT;
    return n;
  endfunction

  // Reference behaviour: one clock edge of the spec's rules.
  function automatic mdl_t model_next(input mdl_t s, input logic [31:0] rpc,
      input logic i_rst, input logic i_halt, input logic i_stall,
      input logic i_br, input logic [31:0] i_bt,
      input logic i_j, input logic [31:0] i_jt);
    mdl_t        n;
    logic        redir;
    logic [31:0] tgt;
    n     = s;
    n.mis = 1'b0;
    redir = i_j || i_br;
    tgt   = i_j ? i_jt : i_bt;
    if (i_rst) begin
      n.mode = S_RESET;
      n.pc   = rpc;
      n.pv   = 1'b0;
      return n;
    end
    case (s.mode)
      S_RESET: n.mode = S_RUN;
      S_HALT:  n.mode = S_HALT;
      S_STALL: begin
        if (i_halt) begin
          n.mode = S_HALT;
          n.pv   = 1'b0;
        end else if (i_stall) begin
          if (redir) begin
            n.pv = 1'b1;
            n.pt = tgt;
          end
        end else if (redir) begin
          n    = redirect_to(n, tgt);
          n.pv = 1'b0;
        end else if (s.pv) begin
          n    = redirect_to(n, s.pt);
          n.pv = 1'b0;
        end else begin
          n.pc   = s.pc + 32'd4;
          n.mode = S_RUN;
        end
      end
      default: begin
        if (i_halt)       n.mode = S_HALT;
        else if (redir)   n = redirect_to(n, tgt);
        else if (i_stall) n.mode = S_STALL;
        else begin
          n.pc   = s.pc + 32'd4;
          n.mode = S_RUN;
        end
      end
    endcase
    return n;
  endfunction

  function automatic exp_t expect_of(input mdl_t m);
    exp_t e;
    e.pc   = m.pc;
    e.four = m.pc + 32'd4;
    e.v    = (m.mode == S_RUN) || (m.mode == S_STALL);
    e.mis  = m.mis;
    e.st   = m.mode;
    return e;
  endfunction

  task automatic step(input logic i_rst, input logic i_halt, input logic i_stall,
      input logic i_br, input logic [31:0] i_bt,
      input logic i_j, input logic [31:0] i_jt);
    mdl_t n0, n1;
    rst = i_rst; halt = i_halt; stall = i_stall;
    br = i_br; bt = i_bt; jmp = i_j; jt = i_jt;
    n0 = model_next(m0, 32'h0000_0000, i_rst, i_halt, i_stall, i_br, i_bt, i_j, i_jt);
    n1 = model_next(m1, RPC1, i_rst, i_halt, i_stall, i_br, i_bt, i_j, i_jt);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
    q0.push_back(expect_of(m0));
    q1.push_back(expect_of(m1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic run_to(input logic [31:0] a);
    for (int k = 0; k < 64 && m0.pc != a; k++) idle(1);
    if (m0.pc != a) begin
      n_err++;
      $display("FAIL run_to: reached pc=%h, required %h", m0.pc, a);
    end
  endtask

  task automatic check(input int inst, input exp_t e, input logic [31:0] pc,
      input logic [31:0] four, input logic v, input logic mis, input logic [2:0] st);
    n_vec++;
    if (pc !== e.pc || four !== e.four || v !== e.v || mis !== e.mis || st !== e.st) begin
      n_err++;
      $display("FAIL dut%0d_vec%0d: got pc=%h four=%h valid=%b mis=%b st=%0d, expected pc=%h four=%h valid=%b mis=%b st=%0d",
               inst, n_vec, pc, four, v, mis, st, e.pc, e.four, e.v, e.mis, e.st);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations away from the edge.
  always @(negedge clk) begin
    if (q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check(0, e0, pc0, four0, v0, mis0, st0);
      check(1, e1, pc1, four1, v1, mis1, st1);
    end
  end

  initial begin
    logic        r_rst, r_halt, r_stall, r_br, r_j;
    logic [31:0] r_bt, r_jt;
    rst = 1'b0; halt = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
    bt = 32'h0; jt = 32'h0;
    m0 = '{S_RESET, 32'h0, 1'b0, 1'b0, 32'h0};
    m1 = '{S_RESET, RPC1, 1'b0, 1'b0, 32'h0};

    // Reset held, then free running (both reset PCs, including wrap).
    do_reset(3);
    idle(5);

    // Branch from 0x20 to 0x100.
    do_reset(1);
    run_to(32'h20);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    idle(3);

    // Stall at 0x40 with branch then jump latched, released to 0xC0.
    do_reset(1);
    run_to(32'h40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC0);
    idle(3);

    // Coincident jump/branch with misaligned jump target.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h203);
    idle(3);

    // Pending discarded by redirect coincident with stall release.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h302, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h501);
    idle(2);

    // Halt at 0x10, ignored inputs afterwards, then reset.
    do_reset(1);
    run_to(32'h10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h50);
    idle(2);
    do_reset(2);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      r_rst   = ($urandom_range(0, 99) < 3);
      r_halt  = ($urandom_range(0, 99) < 2);
      r_stall = ($urandom_range(0, 99) < 35);
      r_br    = ($urandom_range(0, 99) < 15);
      r_j     = ($urandom_range(0, 99) < 10);
      r_bt    = $urandom;
      r_jt    = $urandom;
      step(r_rst, r_halt, r_stall, r_br, r_bt, r_j, r_jt);
    end

    for (int k = 0; k < 10 && q0.size() > 0; k++) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
